// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - elastic pipeline stage register with two-entry skid buffer
module pipe_skid_stage #(
  parameter int CTRL_W      = 2,
  parameter int DATA_W      = 64,
  parameter int RD_W        = 5,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [RD_W-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic              in_fire, out_fire;

  // in_ready is a flop, so acceptance never depends combinationally on out_ready
  assign in_fire   = in_valid & in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_fire  = out_valid & out_ready;

  // Next fill state and entry movement; flush overrides everything and discards in_fire
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_rd_d   = in_rd;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_rd_d   = in_rd;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_rd_d   = in_rd;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Fill-state register, ready flop and entry storage; reset clears every held field
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_rd_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_rd    = main_rd_q;
  assign occupancy = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);

  // Bubble gating keeps a stale RegWrite from leaking out of an empty stage
  generate
    if (ZERO_BUBBLE) begin : g_gate
      assign out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};
    end else begin : g_nogate
      assign out_ctrl = main_ctrl_q;
    end
  endgenerate

endmodule
